linked_fifo_drain: RTL and testbench

Round-robin drain stage that sits directly downstream of `linked_fifo` and empties its logical FIFOs into a single valid/ready output stream. It scans FIFO ids, issues `pop`/`pop_fifo` to `linked_fifo`, and captures `q` one cycle later. Each captured word goes into a 2-entry output buffer tagged with its source FIFO id. Pops are credit-limited so no popped word is ever dropped under downstream backpressure.

---
 rtl/linked_fifo_drain_if.sv | 28 ++
 rtl/linked_fifo_drain.sv | 86 ++++++++
 tb/tb_linked_fifo_drain.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/linked_fifo_drain_if.sv
// Bundle between the drain stage, the upstream linked_fifo and the downstream consumer.
// master = drain stage, slave = environment driving linked_fifo flags/data and out_ready.
interface linked_fifo_drain_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned FIFOS = 8,
    parameter int unsigned ID_W  = $clog2(FIFOS)
);
    logic [FIFOS-1:0] fifo_en;
    logic             pop;
    logic [ID_W-1:0]  pop_fifo;
    logic             empty;
    logic [WIDTH-1:0] q;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [ID_W-1:0]  out_fifo;
    logic             busy;

    modport master (
        input  fifo_en, empty, q, out_ready,
        output pop, pop_fifo, out_valid, out_data, out_fifo, busy
    );

    modport slave (
        output fifo_en, empty, q, out_ready,
        input  pop, pop_fifo, out_valid, out_data, out_fifo, busy
    );
endinterface

// File: rtl/linked_fifo_drain.sv
// Round-robin drain of linked_fifo into one valid/ready stream; pops are credit-limited
// against a 2-entry output buffer so backpressure never drops a popped word.
module linked_fifo_drain #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned FIFOS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    linked_fifo_drain_if.master  bus
);
    localparam int unsigned ID_W  = $clog2(FIFOS);
    localparam int unsigned OCC_W = 2;
    localparam int unsigned SUM_W = 3;

    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic             infl_q, infl_d;
    logic [ID_W-1:0]  infl_id_q, infl_id_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             rd_q, rd_d;
    logic [WIDTH-1:0] data_q [2];
    logic [WIDTH-1:0] data_d [2];
    logic [ID_W-1:0]  id_q [2];
    logic [ID_W-1:0]  id_d [2];

    logic deq_c, credit_c, elig_c, pop_c, wr_idx_c;

    // Pop decision: the buffer must have room for everything already owed to it.
    always_comb begin
        deq_c    = (occ_q != '0) & bus.out_ready;
        credit_c = (SUM_W'(occ_q) + SUM_W'(infl_q) - SUM_W'(deq_c)) <= SUM_W'(1);
        elig_c   = !bus.empty & bus.fifo_en[ptr_q];
        pop_c    = rst & elig_c & credit_c;
    end

    always_comb begin
        ptr_d     = ptr_q + ID_W'(1);
        infl_d    = pop_c;
        infl_id_d = infl_id_q;
        occ_d     = occ_q + OCC_W'(infl_q) - OCC_W'(deq_c);
        rd_d      = rd_q ^ deq_c;
        data_d    = data_q;
        id_d      = id_q;
        // Tail slot is rd+occ mod 2; when full with a deq it reuses the departing head slot.
        wr_idx_c  = rd_q ^ occ_q[0];

        if (elig_c & !credit_c) begin
            ptr_d = ptr_q;
        end
        if (pop_c) begin
            infl_id_d = ptr_q;
        end
        if (infl_q) begin
            data_d[wr_idx_c] = bus.q;
            id_d[wr_idx_c]   = infl_id_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q     <= '0;
            infl_q    <= 1'b0;
            infl_id_q <= '0;
            occ_q     <= '0;
            rd_q      <= 1'b0;
            data_q[0] <= '0;
            data_q[1] <= '0;
            id_q[0]   <= '0;
            id_q[1]   <= '0;
        end else begin
            ptr_q     <= ptr_d;
            infl_q    <= infl_d;
            infl_id_q <= infl_id_d;
            occ_q     <= occ_d;
            rd_q      <= rd_d;
            data_q    <= data_d;
            id_q      <= id_d;
        end
    end

    assign bus.pop       = pop_c;
    assign bus.pop_fifo  = ptr_q;
    assign bus.out_valid = (occ_q != '0);
    assign bus.out_data  = data_q[rd_q];
    assign bus.out_fifo  = id_q[rd_q];
    assign bus.busy      = infl_q | (occ_q != '0);
endmodule

// File: tb/tb_linked_fifo_drain.sv
// Bench for linked_fifo_drain: behavioural linked_fifo model, expected-output scoreboard
// popped by an independent monitor, plus directed checks on pop/pointer behaviour.
module tb_linked_fifo_drain;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned FIFOS = 8;
    localparam int unsigned ID_W  = 3;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [ID_W-1:0]  id;
    } item_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    linked_fifo_drain_if #(.WIDTH(WIDTH), .FIFOS(FIFOS), .ID_W(ID_W)) bus ();
    linked_fifo_drain #(.WIDTH(WIDTH), .FIFOS(FIFOS)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    item_t            exp_q[$];
    logic [WIDTH-1:0] exp_f[FIFOS][$];
    bit               soak = 1'b0;

    // Behavioural linked_fifo: per-id queues, registered read data.
    logic [WIDTH-1:0] fq[FIFOS][$];
    int               cnt[FIFOS]  = '{default: 0};
    int               pops[FIFOS] = '{default: 0};
    logic             push_en = 1'b0;
    logic [ID_W-1:0]  push_id = '0;
    logic [WIDTH-1:0] push_data = '0;
    logic [WIDTH-1:0] q_r = '0;
    int               held = 0;

    assign bus.empty = (cnt[bus.pop_fifo] == 0);
    assign bus.q     = q_r;

    always @(posedge clk) begin
        for (int i = 0; i < FIFOS; i++) begin
            automatic int c = cnt[i];
            if (bus.pop && bus.pop_fifo == ID_W'(i)) c--;
            if (push_en && push_id == ID_W'(i)) c++;
            cnt[i] <= c;
        end
        if (bus.pop) begin
            pops[bus.pop_fifo] <= pops[bus.pop_fifo] + 1;
            if (fq[bus.pop_fifo].size() > 0) q_r <= fq[bus.pop_fifo].pop_front();
        end
        if (push_en) fq[push_id].push_back(push_data);
    end

    // Words popped but not yet delivered; reset discards them.
    always @(posedge clk or negedge rst) begin
        if (!rst) held <= 0;
        else      held <= held + int'(bus.pop) - int'(bus.out_valid & bus.out_ready);
    end

    // Monitor: ordering, stability under stall, and buffer headroom.
    logic  prev_stall = 1'b0;
    item_t prev_item;
    always @(negedge clk) begin
        automatic item_t got = {bus.out_data, bus.out_fifo};
        if (rst) begin
            if (prev_stall) begin
                checks++;
                if (!bus.out_valid || got != prev_item) begin
                    errors++;
                    $display("FAIL stall_stable got v=%0b d=%0d id=%0d want v=1 d=%0d id=%0d",
                             bus.out_valid, got.data, got.id, prev_item.data, prev_item.id);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (soak) begin
                    if (exp_f[got.id].size() == 0) begin
                        errors++;
                        $display("FAIL soak_out unexpected d=%0d id=%0d", got.data, got.id);
                    end else begin
                        automatic logic [WIDTH-1:0] w = exp_f[got.id].pop_front();
                        if (w != got.data) begin
                            errors++;
                            $display("FAIL soak_out id=%0d got %0d want %0d", got.id, got.data, w);
                        end
                    end
                end else if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL out_word unexpected d=%0d id=%0d", got.data, got.id);
                end else begin
                    automatic item_t e = exp_q.pop_front();
                    if (e != got) begin
                        errors++;
                        $display("FAIL out_word got d=%0d id=%0d want d=%0d id=%0d",
                                 got.data, got.id, e.data, e.id);
                    end
                end
            end
            if (bus.pop) begin
                checks++;
                if (held + 1 - int'(bus.out_valid & bus.out_ready) > 2) begin
                    errors++;
                    $display("FAIL buffer_overflow got %0d outstanding want <=2",
                             held + 1 - int'(bus.out_valid & bus.out_ready));
                end
            end
            prev_stall = bus.out_valid & !bus.out_ready;
            prev_item  = got;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic push(input int id, input int data);
        push_en   = 1'b1;
        push_id   = ID_W'(id);
        push_data = WIDTH'(data);
        tick();
        push_en = 1'b0;
    endtask

    task automatic expect_item(input int data, input int id);
        exp_q.push_back({WIDTH'(data), ID_W'(id)});
    endtask

    // Align so the scan starts at id 0 when draining becomes enabled.
    task automatic enable_at_ptr0(input logic [FIFOS-1:0] mask);
        int n = 0;
        while (bus.pop_fifo != '0 && n < 50) begin
            tick();
            n++;
        end
        check("align_ptr0", int'(bus.pop_fifo), 0);
        bus.fifo_en = mask;
    endtask

    function automatic int pending();
        int s = exp_q.size();
        for (int i = 0; i < FIFOS; i++) s += exp_f[i].size();
        return s;
    endfunction

    task automatic wait_idle(input string name);
        int n = 0;
        while ((pending() != 0 || bus.busy) && n < 400) begin
            tick();
            n++;
        end
        check(name, int'(n < 400), 1);
    endtask

    int base[FIFOS];
    task automatic snap();
        for (int i = 0; i < FIFOS; i++) base[i] = pops[i];
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b0;
        bus.fifo_en   = '1;
        bus.out_ready = 1'b0;
        tick();
        tick();

        // Reset with a non-empty, enabled FIFO 0
        push(0, 5);
        tick();
        check("rst_pop", int'(bus.pop), 0);
        check("rst_pop_fifo", int'(bus.pop_fifo), 0);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_out_data", int'(bus.out_data), 0);
        check("rst_out_fifo", int'(bus.out_fifo), 0);

        // Single word, first pop in first cycle out of reset, 2-cycle latency
        expect_item(5, 0);
        bus.out_ready = 1'b1;
        snap();
        rst = 1'b1;
        #1;
        check("first_pop", int'(bus.pop), 1);
        check("first_pop_fifo", int'(bus.pop_fifo), 0);
        tick();
        check("lat_t1_valid", int'(bus.out_valid), 0);
        check("lat_t1_busy", int'(bus.busy), 1);
        tick();
        check("lat_t2_valid", int'(bus.out_valid), 1);
        check("lat_t2_data", int'(bus.out_data), 5);
        wait_idle("single_idle");
        check("single_busy", int'(bus.busy), 0);
        check("single_pops0", pops[0] - base[0], 1);

        // Interleave FIFO 1 and 3
        bus.fifo_en = '0;
        push(1, 10); push(1, 11); push(3, 30); push(3, 31);
        expect_item(10, 1); expect_item(30, 3); expect_item(11, 1); expect_item(31, 3);
        snap();
        enable_at_ptr0('1);
        wait_idle("inter_idle");
        check("inter_pops1", pops[1] - base[1], 2);
        check("inter_pops3", pops[3] - base[3], 2);
        check("inter_pops0", pops[0] - base[0], 0);
        check("inter_pops5", pops[5] - base[5], 0);

        // Backpressure on FIFO 2
        bus.out_ready = 1'b0;
        bus.fifo_en   = '0;
        for (int i = 0; i < 4; i++) begin
            push(2, 20 + i);
            expect_item(20 + i, 2);
        end
        snap();
        enable_at_ptr0('1);
        repeat (30) tick();
        check("bp_pops2", pops[2] - base[2], 2);
        check("bp_pop_low", int'(bus.pop), 0);
        check("bp_ptr_held", int'(bus.pop_fifo), 2);
        check("bp_valid", int'(bus.out_valid), 1);
        check("bp_head", int'(bus.out_data), 20);
        bus.out_ready = 1'b1;
        #1;
        check("bp_release_pop", int'(bus.pop), 1);
        wait_idle("bp_idle");
        check("bp_pops2_total", pops[2] - base[2], 4);

        // Mask: only FIFO 4 enabled, then FIFO 0 as well
        bus.fifo_en = '0;
        push(0, 7);
        push(4, 40);
        expect_item(40, 4);
        snap();
        enable_at_ptr0(8'b0001_0000);
        wait_idle("mask_idle");
        check("mask_pops0", pops[0] - base[0], 0);
        check("mask_pops4", pops[4] - base[4], 1);
        expect_item(7, 0);
        bus.fifo_en[0] = 1'b1;
        wait_idle("mask_idle2");
        check("mask_pops0_after", pops[0] - base[0], 1);

        // Async reset in the cycle after a pop: in-flight word must vanish
        bus.fifo_en = '0;
        push(5, 55);
        push(6, 56);
        enable_at_ptr0(8'b0010_0000);
        begin
            int n = 0;
            while (!bus.pop && n < 20) begin
                tick();
                n++;
            end
            check("ar_saw_pop", int'(bus.pop), 1);
        end
        tick();
        check("ar_busy_before", int'(bus.busy), 1);
        rst = 1'b0;
        #1;
        check("ar_valid", int'(bus.out_valid), 0);
        check("ar_busy", int'(bus.busy), 0);
        tick();
        tick();
        bus.fifo_en = 8'b0100_0000;
        expect_item(56, 6);
        snap();
        rst = 1'b1;
        wait_idle("ar_idle");
        check("ar_pops6", pops[6] - base[6], 1);

        // Random soak: per-FIFO order against expected queues
        soak        = 1'b1;
        bus.fifo_en = '1;
        for (int c = 0; c < 1500; c++) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            if (c % 60 == 0) bus.fifo_en = FIFOS'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                automatic int id = int'($urandom_range(0, FIFOS - 1));
                automatic int d  = int'($urandom_range(0, 255));
                exp_f[id].push_back(WIDTH'(d));
                push(id, d);
            end else begin
                tick();
            end
        end
        bus.fifo_en   = '1;
        bus.out_ready = 1'b1;
        wait_idle("soak_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
